// File: rtl/mips_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, requests words from instruction
// memory and buffers them, tagged with their PC, in a small prefetch queue.
module mips_fetch_queue #(
   parameter int          XLEN     = 32,
   parameter int          DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int          CW       = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc4,
   output logic [CW-1:0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] fpc_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [CW-1:0]   count_reg;

   logic [31:0]     inst_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];

   logic push;
   logic pop;

   // Request depends only on registered occupancy, never on inst_ready.
   assign imem_req  = rst & ~redirect_valid & (count_reg < CW'(DEPTH));
   assign imem_addr = fpc_reg;
   assign count     = count_reg;

   assign push = imem_req & imem_ack;
   assign pop  = inst_valid & inst_ready;

   assign inst_valid = (count_reg != '0);
   assign inst       = inst_valid ? inst_mem[rd_ptr_reg] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg] : '0;
   assign inst_pc4   = inst_valid ? (pc_mem[rd_ptr_reg] + XLEN'(4)) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_reg    <= RESET_PC;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (redirect_valid) begin
         fpc_reg    <= {redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            fpc_reg    <= fpc_reg + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Queue storage carries no reset; a push is already blocked by redirect and reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == AW'(gi))) begin
               inst_mem[gi] <= imem_rdata;
               pc_mem[gi]   <= fpc_reg;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue: fill, refill, streaming, redirect,
// PC wrap-around and asynchronous reset.
module tb_mips_fetch_queue;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic [2:0]  count;

   logic        w_rst;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_inst;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic [2:0]  w_count;

   int vectors;
   int miscompares;

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
   assign w_rdata    = w_addr ^ 32'hA5A5_0000;

   mips_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_pc4(inst_pc4), .count(count)
   );

   mips_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(w_rst),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst),
      .inst_pc(w_pc), .inst_pc4(w_pc4), .count(w_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      step();
      step();
      chk32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk32("rst_imem_req",   {31'b0, imem_req},   32'd0);
      chk32("rst_count",      {29'b0, count},      32'd0);
      chk32("rst_inst",       inst,                32'd0);
      chk32("rst_inst_pc4",   inst_pc4,            32'd0);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk32("fill_addr",  imem_addr,           32'(4 * i));
         chk32("fill_req",   {31'b0, imem_req},   32'd1);
         chk32("fill_count", {29'b0, count},      32'(i));
         step();
      end
      chk32("full_count", {29'b0, count},    32'd4);
      chk32("full_req",   {31'b0, imem_req}, 32'd0);
      chk32("full_addr",  imem_addr,         32'd16);
      chk32("head_inst",  inst,              32'hA5A5_0000);
      chk32("head_pc",    inst_pc,           32'h0);
      chk32("head_pc4",   inst_pc4,          32'h4);
   endtask

   task automatic test_refill();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      #1;
      chk32("refill_count3", {29'b0, count},    32'd3);
      chk32("refill_req",    {31'b0, imem_req}, 32'd1);
      chk32("refill_addr",   imem_addr,         32'd16);
      chk32("refill_headpc", inst_pc,           32'd4);
      step();
      chk32("refill_count4", {29'b0, count},    32'd4);
      chk32("refill_head2",  inst_pc,           32'd4);
      chk32("refill_req0",   {31'b0, imem_req}, 32'd0);
   endtask

   task automatic test_stream();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b0;
      step();
      redirect_valid = 1'b0;
      #1;
      chk32("stream_start_count", {29'b0, count}, 32'd0);
      chk32("stream_start_addr",  imem_addr,      32'h200);
      inst_ready = 1'b1; imem_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk32("stream_count", {29'b0, count},      32'd1);
         chk32("stream_valid", {31'b0, inst_valid}, 32'd1);
         chk32("stream_pc",    inst_pc,             32'h200 + 32'(4 * i));
         chk32("stream_inst",  inst,                (32'h200 + 32'(4 * i)) ^ 32'hA5A5_0000);
      end
   endtask

   task automatic test_redirect();
      inst_ready = 1'b0;
      step();
      step();
      chk32("redir_pre_count", {29'b0, count}, 32'd3);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; inst_ready = 1'b1; imem_ack = 1'b1;
      #1;
      chk32("redir_req0", {31'b0, imem_req}, 32'd0);
      step();
      redirect_valid = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0;
      #1;
      chk32("redir_count",  {29'b0, count},      32'd0);
      chk32("redir_valid",  {31'b0, inst_valid}, 32'd0);
      chk32("redir_addr",   imem_addr,           32'h100);
      chk32("redir_inst0",  inst,                32'd0);
      // Ready on an empty queue must not underflow.
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk32("empty_pop_count", {29'b0, count}, 32'd0);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      chk32("redir_head_pc",   inst_pc,  32'h100);
      chk32("redir_head_pc4",  inst_pc4, 32'h104);
      chk32("redir_head_inst", inst,     32'hA5A5_0100);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0104; imem_ack = 1'b1;
      #1;
      chk32("same_redir_req0", {31'b0, imem_req}, 32'd0);
      step();
      redirect_valid = 1'b0; imem_ack = 1'b0;
      #1;
      chk32("same_redir_count", {29'b0, count}, 32'd0);
      chk32("same_redir_addr",  imem_addr,      32'h104);
   endtask

   task automatic test_async_reset();
      imem_ack = 1'b1; inst_ready = 1'b0;
      step();
      step();
      chk32("areset_pre_count", {29'b0, count}, 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk32("areset_valid", {31'b0, inst_valid}, 32'd0);
      chk32("areset_req",   {31'b0, imem_req},   32'd0);
      chk32("areset_count", {29'b0, count},      32'd0);
      step();
      chk32("areset_hold_count", {29'b0, count}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk32("areset_addr", imem_addr,         32'h0);
      chk32("areset_req1", {31'b0, imem_req}, 32'd1);
      imem_ack = 1'b0;
   endtask

   task automatic test_wrap();
      w_ack = 1'b1; w_ready = 1'b0;
      step();
      w_rst = 1'b1;
      #1;
      chk32("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      step();
      chk32("wrap_addr1", w_addr, 32'hFFFF_FFFC);
      step();
      chk32("wrap_addr2", w_addr, 32'h0000_0000);
      step();
      w_ack = 1'b0;
      chk32("wrap_count", {29'b0, w_count}, 32'd3);
      chk32("wrap_pc0",   w_pc,  32'hFFFF_FFF8);
      chk32("wrap_pc4_0", w_pc4, 32'hFFFF_FFFC);
      w_ready = 1'b1;
      step();
      chk32("wrap_pc1",   w_pc,   32'hFFFF_FFFC);
      chk32("wrap_pc4_1", w_pc4,  32'h0000_0000);
      chk32("wrap_inst1", w_inst, 32'h5A5A_FFFC);
      step();
      chk32("wrap_pc2",   w_pc,  32'h0000_0000);
      chk32("wrap_pc4_2", w_pc4, 32'h0000_0004);
      w_ready = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      w_rst = 1'b0; w_ack = 1'b0; w_ready = 1'b0;
      test_reset();
      test_refill();
      test_stream();
      test_redirect();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
